// File: rtl/sclk_arb_pkg.sv
// rtl/sclk_arb_pkg.sv - shared state type and slice helper for the sclk burst arbiter
package sclk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Low bit of requester idx's field inside a packed per-requester bus of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sclk_burst_arbiter_if.sv
// rtl/sclk_burst_arbiter_if.sv - requester-facing bus of the sclk burst arbiter
interface sclk_burst_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DIV_W   = 32,
  parameter int LEN_W   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DIV_W-1:0] div;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     sclk;
  logic                     sclk_rise;
  logic                     busy;

  modport master (
    output req, div, len,
    input  gnt, done, sclk, sclk_rise, busy
  );

  modport slave (
    input  req, div, len,
    output gnt, done, sclk, sclk_rise, busy
  );
endinterface

// File: rtl/sclk_rr_arbiter.sv
// rtl/sclk_rr_arbiter.sv - combinational one-hot winner select starting at i_ptr
// SCLK_FIXED_PRIO_EN: ignore i_ptr, lowest active index always wins.
module sclk_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);
  logic w_found;

`ifdef SCLK_FIXED_PRIO_EN
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/sclk_burst_arbiter.sv
// rtl/sclk_burst_arbiter.sv - shares one sclk generator among requesters, one burst per grant
// SCLK_FIXED_PRIO_EN: drop the round-robin pointer and use fixed lowest-index priority.
module sclk_burst_arbiter
  import sclk_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DIV_W   = 32,
  parameter int LEN_W   = 16
) (
  input logic                clk,
  input logic                reset,
  sclk_burst_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               r_state, w_next;
  logic [NUM_REQ-1:0]   r_gnt, r_done, w_win;
  logic                 r_sclk, r_rise, r_busy;
  logic [DIV_W-1:0]     r_div, r_hc, w_div_sel;
  logic [LEN_W-1:0]     r_len, r_pc, w_len_sel;
  logic [IDX_W-1:0]     r_idx, w_win_idx, w_ptr;
  logic                 w_tog, w_last_fall;

`ifdef SCLK_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  // Pointer holds the index searched first, i.e. last winner + 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ptr <= '0;
    else if (r_state == DONE)
      r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
  end
  assign w_ptr = r_ptr;
`endif

  sclk_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req (bus.req),
    .i_ptr (w_ptr),
    .o_gnt (w_win)
  );

  always_comb begin
    w_div_sel = '0;
    w_len_sel = '0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_div_sel = bus.div[slice_lo(i, DIV_W) +: DIV_W];
        w_len_sel = bus.len[slice_lo(i, LEN_W) +: LEN_W];
        w_win_idx = IDX_W'(i);
      end
    end
  end

  assign w_tog       = (r_state == RUN) && (r_len != '0) && (r_hc == r_div);
  assign w_last_fall = w_tog && r_sclk && (LEN_W'(r_pc + 1'b1) == r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|bus.req) w_next = RUN;
      RUN:     if ((r_len == '0) || w_last_fall) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt  <= '0;
      r_done <= '0;
      r_sclk <= 1'b0;
      r_rise <= 1'b0;
      r_busy <= 1'b0;
      r_hc   <= '0;
      r_pc   <= '0;
      r_div  <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else begin
      r_done <= '0;
      r_rise <= 1'b0;
      r_busy <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_gnt  <= w_win;
            r_idx  <= w_win_idx;
            r_div  <= w_div_sel;
            r_len  <= w_len_sel;
            r_hc   <= '0;
            r_pc   <= '0;
            r_sclk <= 1'b0;
          end
        end
        RUN: begin
          if (w_tog) begin
            r_hc   <= '0;
            r_sclk <= ~r_sclk;
            r_rise <= ~r_sclk;
            if (r_sclk) r_pc <= r_pc + 1'b1;
          end else if (r_len != '0) begin
            r_hc <= r_hc + 1'b1;
          end
          if (w_next == DONE) begin
            r_done <= r_gnt;
            r_gnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.sclk      = r_sclk;
  assign bus.sclk_rise = r_rise;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_sclk_burst_arbiter.sv
// tb/tb_sclk_burst_arbiter.sv - self-checking bench for sclk_burst_arbiter
module tb_sclk_burst_arbiter;
  localparam int NUM_REQ = 2;
  localparam int DIV_W   = 32;
  localparam int LEN_W   = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_last   = NUM_REQ - 1;
  int   cyc      = 0;

  sclk_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

  sclk_burst_arbiter #(.NUM_REQ(NUM_REQ), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int i, input int d, input int l);
    bus.div[i*DIV_W +: DIV_W] = DIV_W'(d);
    bus.len[i*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [NUM_REQ-1:0] g);
    for (int i = 0; i < NUM_REQ; i++)
      if (g === oh(i)) return i;
    return -1;
  endfunction

  // Reference arbitration: search upward from the last winner + 1.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] m);
`ifdef SCLK_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++)
      if (m[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++)
      if (m[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  // Called at a sample point with req already driven; expects the grant on the next edge.
  // opt[0]: scramble div/len after grant, opt[1]: drop req right after grant.
  task automatic observe_burst(input int idx, input int d, input int l, input int opt, input string nm);
    logic [NUM_REQ-1:0] exp_oh;
    logic exp_s, busy_d, busy_i;
    int n, gnt_cnt, rises, sclk_err, done_at, done_cnt;
    exp_oh = oh(idx);
    gnt_cnt = 0; rises = 0; sclk_err = 0; done_at = -1; done_cnt = 0;
    busy_d = 1'b0; busy_i = 1'b1;
    n = (l == 0) ? 1 : 2 * l * (d + 1);
    tick();
    n_checks++;
    if (bus.gnt !== exp_oh) begin
      n_fail++;
      $display("FAIL %s grant_latency: gnt=%b required %b", nm, bus.gnt, exp_oh);
    end
    if (opt[0])
      for (int i = 0; i < NUM_REQ; i++) set_cfg(i, $urandom_range(0, 7), $urandom_range(0, 7));
    if (opt[1]) bus.req[idx] = 1'b0;
    for (int c = 0; c <= n + 1; c++) begin
      if (c > 0) tick();
      if (bus.gnt === exp_oh) gnt_cnt++;
      exp_s = (l != 0 && c < n) ? (((c / (d + 1)) % 2) == 1) : 1'b0;
      if (bus.sclk !== exp_s) sclk_err++;
      if (bus.sclk_rise === 1'b1) rises++;
      if (bus.done !== '0) begin
        done_cnt++;
        if (bus.done === exp_oh && done_at < 0) done_at = c;
        bus.req[idx] = 1'b0;
      end
      if (c == n)     busy_d = bus.busy;
      if (c == n + 1) busy_i = bus.busy;
    end
    m_last = idx;
    n_checks++;
    if (gnt_cnt != n) begin n_fail++; $display("FAIL %s gnt_cycles: got %0d required %0d", nm, gnt_cnt, n); end
    n_checks++;
    if (rises != l) begin n_fail++; $display("FAIL %s sclk_rises: got %0d required %0d", nm, rises, l); end
    n_checks++;
    if (sclk_err != 0) begin n_fail++; $display("FAIL %s sclk_waveform: %0d wrong cycles required 0", nm, sclk_err); end
    n_checks++;
    if (done_at != n) begin n_fail++; $display("FAIL %s done_cycle: got %0d required %0d", nm, done_at, n); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d required 1", nm, done_cnt); end
    n_checks++;
    if (busy_d !== 1'b1 || busy_i !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: done=%b idle=%b required 1/0", nm, busy_d, busy_i);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset   = 1'b0;
    bus.req = '1;
    set_cfg(0, 0, 1);
    set_cfg(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.gnt !== '0 || bus.sclk !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== '0 || bus.sclk_rise !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_hold: %0d active cycles required 0", bad); end
    reset  = 1'b1;
    m_last = NUM_REQ - 1;
    observe_burst(rr_pick(bus.req), 0, 1, 0, "reset_release");
    bus.req = '0;
  endtask

  task automatic test_single_burst();
    bus.req = '0;
    set_cfg(0, 3, 2);
    bus.req[0] = 1'b1;
    observe_burst(rr_pick(bus.req), 3, 2, 0, "single");
  endtask

  task automatic test_round_robin();
    int who, exp, t, last_stamp;
    set_cfg(0, 0, 1);
    set_cfg(1, 0, 1);
    bus.req = '1;
    last_stamp = 0;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (bus.gnt === '0 && t < 12) begin tick(); t++; end
      who = idx_of(bus.gnt);
      exp = rr_pick('1);
      m_last = exp;
      n_checks++;
      if (who != exp) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d required %0d", g, who, exp); end
      if (g > 0) begin
        n_checks++;
        if (cyc - last_stamp != 4) begin
          n_fail++;
          $display("FAIL rr_spacing[%0d]: got %0d required 4", g, cyc - last_stamp);
        end
      end
      last_stamp = cyc;
      t = 0;
      while (bus.gnt !== '0 && t < 12) begin tick(); t++; end
    end
    bus.req = '0;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy=%b required 0", bus.busy); end
  endtask

  task automatic test_edges();
    bus.req = '0;
    set_cfg(0, 0, 0);
    bus.req[0] = 1'b1;
    observe_burst(rr_pick(bus.req), 0, 0, 0, "len0");
    set_cfg(0, -1, 0);
    bus.req[0] = 1'b1;
    observe_burst(rr_pick(bus.req), -1, 0, 0, "divmax_len0");
    set_cfg(0, 0, 3);
    bus.req[0] = 1'b1;
    observe_burst(rr_pick(bus.req), 0, 3, 0, "div0_len3");
  endtask

  task automatic test_mid_reset();
    int exp, dcnt;
    bus.req = '0;
    set_cfg(0, 3, 4);
    bus.req[0] = 1'b1;
    exp = rr_pick(bus.req);
    tick();
    n_checks++;
    if (bus.gnt !== oh(exp)) begin n_fail++; $display("FAIL midrst_grant: gnt=%b required %b", bus.gnt, oh(exp)); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (bus.sclk !== 1'b1) begin n_fail++; $display("FAIL midrst_sclk_before: sclk=%b required 1", bus.sclk); end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt, bus.sclk, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: gnt=%b sclk=%b busy=%b required all 0", bus.gnt, bus.sclk, bus.busy);
    end
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done !== '0) dcnt++;
    end
    n_checks++;
    if (dcnt != 0) begin n_fail++; $display("FAIL midrst_done: %0d pulses required 0", dcnt); end
    m_last  = NUM_REQ - 1;
    bus.req = '1;
    reset   = 1'b1;
    observe_burst(rr_pick(bus.req), 3, 4, 0, "midrst_fresh");
    bus.req = '0;
  endtask

  task automatic test_req_drop();
    bus.req = '0;
    set_cfg(1, 2, 2);
    bus.req[1] = 1'b1;
    observe_burst(rr_pick(bus.req), 2, 2, 2, "req_drop");
  endtask

  task automatic test_random();
    int dv[NUM_REQ];
    int lv[NUM_REQ];
    logic [NUM_REQ-1:0] m;
    int w;
    for (int it = 0; it < 30; it++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        dv[i] = $urandom_range(0, 3);
        lv[i] = $urandom_range(0, 3);
        set_cfg(i, dv[i], lv[i]);
      end
      bus.req = m;
      w = rr_pick(m);
      observe_burst(w, dv[w], lv[w], 1, "random");
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  initial begin
    bus.req = '0;
    bus.div = '0;
    bus.len = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_edges();
    test_mid_reset();
    test_req_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
